// File: rtl/neuron_accum_pkg.sv
// Shared fixed-point definitions for the neuron datapath: zero2one_t (unsigned Q1.15,
// 0.0..1.0), frac_t (signed Q4.12), the product helper and the accumulator FSM state.
package neuron_accum_pkg;

    localparam int FRAC_W = 16;
    localparam int Z2O_W  = 16;
    localparam int Z2O_FB = 15;

    typedef logic signed [FRAC_W-1:0] frac_t;
    typedef logic        [Z2O_W-1:0]  zero2one_t;

    localparam frac_t     FRAC_MAX     = 16'sh7FFF;
    localparam frac_t     FRAC_MIN     = 16'sh8000;
    localparam frac_t     FRAC_ONE     = 16'sh1000;
    localparam zero2one_t ZERO2ONE_MAX = 16'h8000;
    localparam zero2one_t ZERO2ONE_MIN = 16'h0000;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // x is clamped to 1.0 before the multiply, so |result| <= |w| and always fits frac_t.
    // The product is rounded toward minus infinity (arithmetic shift).
    function automatic frac_t zero2one_mul_frac(input zero2one_t x, input frac_t w);
        zero2one_t                     xc;
        logic signed [Z2O_W+FRAC_W:0]  prod;
        xc   = (x > ZERO2ONE_MAX) ? ZERO2ONE_MAX : x;
        prod = $signed({1'b0, xc}) * w;
        return frac_t'(prod >>> Z2O_FB);
    endfunction

endpackage

// File: rtl/neuron_accum_if.sv
// Pair-input / sum-output handshake bundle of the neuron accumulator.
// master = upstream + activation stage side, slave = accumulator.
interface neuron_accum_if;
    import neuron_accum_pkg::*;

    logic      in_valid;
    logic      in_ready;
    zero2one_t in_x;
    frac_t     in_w;
    logic      out_valid;
    logic      out_ready;
    frac_t     out_sum;
    logic      out_sat;

    modport master (
        output in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_sum, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_sum, out_sat
    );

endinterface

// File: rtl/neuron_accum.sv
// Neuron weighted-sum accumulator: sums N products x*w, then holds the sum until consumed.
// Build option NEURON_ACCUM_SATURATE_EN: clamp each step and flag out_sat; otherwise wrap.
module neuron_accum
    import neuron_accum_pkg::*;
#(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    neuron_accum_if.slave bus
);

    localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    frac_t            acc_q;
    logic             sat_q;
    frac_t            out_sum_q;
    logic             out_sat_q;
    logic             in_ready_q;
    logic             out_valid_q;

    frac_t prod;
    frac_t acc_d;
    logic  step_ovf;
    logic  sat_d;

`ifdef NEURON_ACCUM_SATURATE_EN
    logic [FRAC_W:0] step_wide;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        prod     = zero2one_mul_frac(bus.in_x, bus.in_w);
        acc_d    = acc_q;
        step_ovf = 1'b0;
`ifdef NEURON_ACCUM_SATURATE_EN
        step_wide = {acc_q[FRAC_W-1], acc_q} + {prod[FRAC_W-1], prod};
        if (step_wide[FRAC_W] != step_wide[FRAC_W-1]) begin
            step_ovf = 1'b1;
            acc_d    = step_wide[FRAC_W] ? FRAC_MIN : FRAC_MAX;
        end else begin
            acc_d = step_wide[FRAC_W-1:0];
        end
`else
        acc_d = acc_q + prod;
`endif
        sat_d = sat_q | step_ovf;
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (bus.in_valid && in_ready_q) begin
                        if (cnt_q == CNT_LAST) begin
                            // Final beat: publish the sum and rearm the accumulator for the next pass.
                            cnt_q       <= '0;
                            acc_q       <= '0;
                            sat_q       <= 1'b0;
                            out_sum_q   <= acc_d;
                            out_sat_q   <= sat_d;
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            acc_q <= acc_d;
                            sat_q <= sat_d;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_sum_q   <= '0;
                        out_sat_q   <= 1'b0;
                        state_q     <= ST_ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_accum.sv
// Self-checking bench for neuron_accum: an N=16 and an N=4 instance, an integer-arithmetic
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_neuron_accum;
    import neuron_accum_pkg::*;

    logic clk;
    logic rst;

    logic      iv   [2];
    zero2one_t ix   [2];
    frac_t     iw   [2];
    logic      ordy [2];
    logic      irdy [2];
    logic      ov   [2];
    frac_t     osum [2];
    logic      osat [2];

    int n_tests = 0;
    int n_fail  = 0;

    neuron_accum_if bus16 ();
    neuron_accum_if bus4 ();

    assign bus16.in_valid  = iv[0];
    assign bus16.in_x      = ix[0];
    assign bus16.in_w      = iw[0];
    assign bus16.out_ready = ordy[0];
    assign irdy[0] = bus16.in_ready;
    assign ov[0]   = bus16.out_valid;
    assign osum[0] = bus16.out_sum;
    assign osat[0] = bus16.out_sat;

    assign bus4.in_valid  = iv[1];
    assign bus4.in_x      = ix[1];
    assign bus4.in_w      = iw[1];
    assign bus4.out_ready = ordy[1];
    assign irdy[1] = bus4.in_ready;
    assign ov[1]   = bus4.out_valid;
    assign osum[1] = bus4.out_sum;
    assign osat[1] = bus4.out_sat;

    neuron_accum #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    neuron_accum #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_sum(input string name, input int k, input frac_t exp);
        check(name, {16'h0, osum[k]}, {16'h0, exp});
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic int n_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    function automatic void model_step(input int acc, input zero2one_t x, input frac_t w,
                                       output int nacc, output bit ovf);
        longint xc;
        longint p;
        longint s;
        shortint t;
        xc  = (x > ZERO2ONE_MAX) ? longint'(ZERO2ONE_MAX) : longint'(x);
        p   = (xc * longint'(w)) >>> 15;
        s   = longint'(acc) + p;
        ovf = 1'b0;
`ifdef NEURON_ACCUM_SATURATE_EN
        if (s > 32767) begin
            s = 32767; ovf = 1'b1;
        end else if (s < -32768) begin
            s = -32768; ovf = 1'b1;
        end
        nacc = int'(s);
`else
        t    = shortint'(s);
        nacc = int'(t);
`endif
    endfunction

    int m_acc  [2];
    int m_cnt  [2];
    bit m_sat  [2];
    bit m_hold [2];
    int m_res  [2];
    bit m_rsat [2];

    task automatic mon(input int k);
        frac_t exp_sum;
        int    nacc;
        bit    ovf;
        exp_sum = m_hold[k] ? frac_t'(m_res[k]) : frac_t'(0);
        check($sformatf("u%0d.in_ready", k), {31'h0, irdy[k]}, {31'h0, !m_hold[k]});
        check($sformatf("u%0d.out_valid", k), {31'h0, ov[k]}, {31'h0, m_hold[k]});
        check_sum($sformatf("u%0d.out_sum", k), k, exp_sum);
        if (m_hold[k])
            check($sformatf("u%0d.out_sat", k), {31'h0, osat[k]}, {31'h0, m_rsat[k]});
        if (rst) begin
            m_hold[k] = 1'b0; m_cnt[k] = 0; m_acc[k] = 0; m_sat[k] = 1'b0;
        end else if (m_hold[k]) begin
            if (ordy[k]) m_hold[k] = 1'b0;
        end else if (iv[k]) begin
            model_step(m_acc[k], ix[k], iw[k], nacc, ovf);
            m_acc[k] = nacc;
            m_sat[k] = m_sat[k] | ovf;
            m_cnt[k]++;
            if (m_cnt[k] == n_of(k)) begin
                m_res[k]  = m_acc[k];
                m_rsat[k] = m_sat[k];
                m_hold[k] = 1'b1;
                m_cnt[k]  = 0; m_acc[k] = 0; m_sat[k] = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int k, input zero2one_t x, input frac_t w, input int gap);
        int t;
        iv[k] = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        iv[k] = 1'b1; ix[k] = x; iw[k] = w;
        t = 0;
        while (irdy[k] !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        check($sformatf("u%0d.send_accept", k), {31'h0, irdy[k]}, 32'd1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k);
        int t;
        t = 0;
        while (ov[k] !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check($sformatf("u%0d.wait_valid", k), {31'h0, ov[k]}, 32'd1);
    endtask

    task automatic consume(input int k);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    frac_t c_w   [4] = '{16'sh1000, 16'sh0800, 16'shFC00, 16'sh0400};
    zero2one_t m_x [4] = '{16'h6000, 16'h2000, 16'h8000, 16'h8000};
    frac_t m_w   [4] = '{16'shFFFD, 16'sh1000, 16'shF000, 16'sh0800};
    frac_t g_exp [3] = '{16'sh0A00, 16'sh1A00, 16'sh2A00};

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ix[k] = '0; iw[k] = '0; ordy[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.rst_in_ready", k), {31'h0, irdy[k]}, 32'd1);
            check($sformatf("u%0d.rst_out_valid", k), {31'h0, ov[k]}, 32'd0);
            check_sum($sformatf("u%0d.rst_out_sum", k), k, 16'sh0000);
            check($sformatf("u%0d.rst_out_sat", k), {31'h0, osat[k]}, 32'd0);
        end

        // N=16, x=1.0, w=0: result visible right after the 16th beat
        for (int i = 0; i < 16; i++) send(0, ZERO2ONE_MAX, 16'sh0000, 0);
        check("zero_w.latency", {31'h0, ov[0]}, 32'd1);
        check_sum("zero_w.sum", 0, 16'sh0000);
        check("zero_w.sat", {31'h0, osat[0]}, 32'd0);
        consume(0);

        // N=4, weights 1.0, 0.5, -0.25, 0.25 with random gaps -> 1.5
        for (int i = 0; i < 4; i++) send(1, ZERO2ONE_MAX, c_w[i], int'($urandom_range(0, 3)));
        check("n4.latency", {31'h0, ov[1]}, 32'd1);
        check_sum("n4.sum", 1, 16'sh1800);
        repeat (3) begin
            @(posedge clk); #1;
            check("n4.in_ready_held", {31'h0, irdy[1]}, 32'd0);
        end
        consume(1);

        // N=4, mixed inputs, negative product rounded toward -inf: -3+1024-4096+2048
        for (int i = 0; i < 4; i++) send(1, m_x[i], m_w[i], 0);
        check_sum("mixed.sum", 1, 16'shFBFD);
        consume(1);

        // Overflow: 16 x (1.0 * FRAC_MAX)
        for (int i = 0; i < 16; i++) send(0, ZERO2ONE_MAX, FRAC_MAX, 0);
        wait_valid(0);
`ifdef NEURON_ACCUM_SATURATE_EN
        check_sum("ovf.sum", 0, FRAC_MAX);
        check("ovf.sat", {31'h0, osat[0]}, 32'd1);
`else
        check_sum("ovf.sum", 0, 16'shFFF0);
        check("ovf.sat", {31'h0, osat[0]}, 32'd0);
`endif
        consume(0);

        // Hold 10 cycles with out_ready=0 while upstream keeps offering pairs: 16 x 0.0625
        for (int i = 0; i < 16; i++) send(0, 16'h4000, 16'sh0200, 0);
        wait_valid(0);
        iv[0] = 1'b1; ix[0] = ZERO2ONE_MAX; iw[0] = FRAC_ONE;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_sum("hold.sum", 0, 16'sh1000);
            check("hold.sat", {31'h0, osat[0]}, 32'd0);
            check("hold.in_ready", {31'h0, irdy[0]}, 32'd0);
        end
        iv[0] = 1'b0;
        consume(0);
        for (int i = 0; i < 16; i++) send(0, ZERO2ONE_MAX, 16'sh0010, 0);
        check_sum("after_hold.sum", 0, 16'sh0100);
        consume(0);

        // Reset mid-evaluation (u16 after 7 beats) and mid-hold (u4), with handshakes pending
        for (int i = 0; i < 7; i++) send(0, ZERO2ONE_MAX, FRAC_ONE, 0);
        for (int i = 0; i < 4; i++) send(1, ZERO2ONE_MAX, FRAC_ONE, 0);
        check("pre_rst.u4_valid", {31'h0, ov[1]}, 32'd1);
        iv[0] = 1'b1; ix[0] = ZERO2ONE_MAX; iw[0] = FRAC_ONE; ordy[1] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; iv[0] = 1'b0; ordy[1] = 1'b0;
        check("post_rst.u4_valid", {31'h0, ov[1]}, 32'd0);
        check_sum("post_rst.u4_sum", 1, 16'sh0000);
        check("post_rst.u16_ready", {31'h0, irdy[0]}, 32'd1);
        for (int i = 0; i < 16; i++) send(0, ZERO2ONE_MAX, 16'sh0080, 0);
        check("fresh.latency", {31'h0, ov[0]}, 32'd1);
        check_sum("fresh.sum", 0, 16'sh0800);
        consume(0);

        // Three back-to-back N=4 evaluations with out_ready held high
        ordy[1] = 1'b1;
        fork
            begin
                for (int i = 1; i <= 12; i++) send(1, ZERO2ONE_MAX, frac_t'(i * 256), 0);
            end
            begin
                for (int e = 0; e < 3; e++) begin
                    int t;
                    t = 0;
                    @(negedge clk);
                    while (ov[1] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
                    check("b2b.pulse", {31'h0, ov[1]}, 32'd1);
                    check_sum("b2b.sum", 1, g_exp[e]);
                    @(negedge clk);
                    check("b2b.pulse_width", {31'h0, ov[1]}, 32'd0);
                end
            end
        join
        ordy[1] = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_accum.md
NEURON_ACCUM -- requirements
Module: neuron_accum

Interface
REQ-001 SHALL have parameter N, default 16, giving the number of input/weight pairs per neuron evaluation.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the upstream pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block accepts a pair this cycle.
REQ-006 SHALL have port in_x, input, zero2one_t, the neuron input sample.
REQ-007 SHALL have port in_w, input, frac_t, the weight paired with in_x.
REQ-008 SHALL have port out_valid, output, 1 bit, meaning out_sum is complete.
REQ-009 SHALL have port out_ready, input, 1 bit, meaning the downstream activation stage consumes the sum.
REQ-010 SHALL have port out_sum, output, frac_t, the weighted sum over N pairs.
REQ-011 SHALL have port out_sat, output, 1 bit, set if any accumulation step saturated during this evaluation.

Function
REQ-012 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 SHALL count accepted beats (in_valid&&in_ready) in a counter of width $clog2(N), range 0..N-1.
REQ-014 SHALL, on each accepted beat, set acc <= acc + zero2one_mul_frac(in_x, in_w) and increment the counter.
REQ-015 SHALL, on the accepted beat with counter==N-1, reset the counter to 0 and enter HOLD, so out_valid rises the next cycle (latency 1 cycle after the Nth beat).
REQ-016 SHALL drive out_sum=acc and keep out_sum and out_sat stable while out_valid=1 and out_ready=0.
REQ-017 SHALL, on out_valid&&out_ready in HOLD, clear acc and out_sat and return to ACCUM; in_ready rises the following cycle (no same-cycle pass-through).
REQ-018 SHALL ignore in_x and in_w whenever in_valid=0 or in_ready=0; the counter holds.
REQ-019 SHALL, when N==1, enter HOLD after every single accepted beat.
REQ-020 SHALL drive out_sum=0 in ACCUM (partial sums are not exposed).

Reset
REQ-021 SHALL, when rst=1 at a clock edge, set state=ACCUM, counter=0, acc=0, out_sat=0, giving in_ready=1, out_valid=0, out_sum=0 the next cycle.
REQ-022 SHALL let reset take priority over any handshake in the same cycle and discard any partial or held sum mid-evaluation.

Configuration
REQ-023 SHALL, with NEURON_ACCUM_SATURATE_EN defined, clamp each step's signed result to FRAC_MAX/FRAC_MIN on overflow and set out_sat sticky for the evaluation.
REQ-024 SHALL, without NEURON_ACCUM_SATURATE_EN, wrap two's-complement on overflow and tie out_sat to 0.

Structure
REQ-025 SHALL take zero2one_t, frac_t, zero2one_mul_frac, FRAC_MAX, FRAC_MIN, ZERO2ONE_MAX and ZERO2ONE_MIN from the shared defs package; no new typedefs are local to this block.
REQ-026 SHALL be a single module with no sub-module; its out_sum/out_valid feed the neuron activation stage directly.

Verification
REQ-027 SHALL cover: N=16, every in_x=ZERO2ONE_MAX, every in_w=0 -> out_valid one cycle after beat 16, out_sum=0, out_sat=0.
REQ-028 SHALL cover: N=4, in_x=ZERO2ONE_MAX, weights 1.0,0.5,-0.25,0.25 with random in_valid gaps -> out_sum=1.5 and in_ready=0 until consumed.
REQ-029 SHALL cover: out_ready held 0 for 10 cycles in HOLD -> out_sum/out_sat constant, in_ready=0, extra in_valid beats not absorbed.
REQ-030 SHALL cover: 16 beats of in_x=ZERO2ONE_MAX, in_w=FRAC_MAX -> out_sum=FRAC_MAX, out_sat=1 with the macro; wrapped value and out_sat=0 without it.
REQ-031 SHALL cover: rst asserted after beat 7 of 16, then 16 fresh beats -> the result reflects only the fresh beats.
REQ-032 SHALL cover: back-to-back evaluations with out_ready=1 -> out_valid pulses 1 cycle each, no pair lost or double-counted across 3 evaluations.
